// File: rtl/fa_v1.sv
// Single-bit full adder with an optional output register.
// The combinational result {carry, s} = a + b + c_in is always computed.
// A registered copy (sum_q, c_out_q) is always present. REG_OUT chooses
// whether sum/c_out show the combinational result or the registered copy.
module fa_v1 #(
    parameter int REG_OUT = 0
) (
    output logic sum,
    output logic c_out,
    input  logic a,
    input  logic b,
    input  logic c_in,
    input  logic clk,
    input  logic rst,
    output logic sum_q,
    output logic c_out_q
);

    logic s_next;
    logic carry_next;
    logic sum_q_reg;
    logic c_out_q_reg;

    // Full-adder equations: the sum is the parity of the three inputs, and
    // the carry is their majority.
    always_comb begin
        s_next     = a ^ b ^ c_in;
        carry_next = (a & b) | (a & c_in) | (b & c_in);
    end

    // Output register. Reset is synchronous and takes priority over data,
    // so a reset edge clears both bits whatever the inputs are.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q_reg   <= 1'b0;
            c_out_q_reg <= 1'b0;
        end else begin
            sum_q_reg   <= s_next;
            c_out_q_reg <= carry_next;
        end
    end

    assign sum_q   = sum_q_reg;
    assign c_out_q = c_out_q_reg;

    // Choose what drives the primary outputs. In the combinational build,
    // sum/c_out never see clk or rst.
    generate
        if (REG_OUT != 0) begin : g_reg_out
            assign sum   = sum_q_reg;
            assign c_out = c_out_q_reg;
        end else begin : g_comb_out
            assign sum   = s_next;
            assign c_out = carry_next;
        end
    endgenerate

endmodule

// File: tb/tb_fa_v1.sv
// Directed bench for fa_v1. It drives one combinational instance and one
// registered instance from the same inputs and checks both against a
// hand-written truth table.
module tb_fa_v1;

    logic clk;
    logic rst;
    logic a;
    logic b;
    logic c_in;

    logic sum0, c_out0, sum_q0, c_out_q0;
    logic sum1, c_out1, sum_q1, c_out_q1;

    int n_checks;
    int n_pass;

    // Expected {sum, c_out}, indexed by {a, b, c_in}.
    logic [1:0] exp_tab [8];

    fa_v1 #(.REG_OUT(0)) dut0 (
        .sum     (sum0),
        .c_out   (c_out0),
        .a       (a),
        .b       (b),
        .c_in    (c_in),
        .clk     (clk),
        .rst     (rst),
        .sum_q   (sum_q0),
        .c_out_q (c_out_q0)
    );

    fa_v1 #(.REG_OUT(1)) dut1 (
        .sum     (sum1),
        .c_out   (c_out1),
        .a       (a),
        .b       (b),
        .c_in    (c_in),
        .clk     (clk),
        .rst     (rst),
        .sum_q   (sum_q1),
        .c_out_q (c_out_q1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic apply(input int v);
        logic [2:0] bits;
        bits = 3'(v);
        a    = bits[2];
        b    = bits[1];
        c_in = bits[0];
    endtask

    initial begin
        logic [1:0] exp_v;
        n_checks = 0;
        n_pass   = 0;
        exp_tab[0] = 2'b00;
        exp_tab[1] = 2'b10;
        exp_tab[2] = 2'b10;
        exp_tab[3] = 2'b01;
        exp_tab[4] = 2'b10;
        exp_tab[5] = 2'b01;
        exp_tab[6] = 2'b01;
        exp_tab[7] = 2'b11;

        rst = 1'b1;
        apply(0);

        // Reset state of both registered paths.
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_q0", {sum_q0, c_out_q0}, 2'b00);
        check("reset_q1", {sum_q1, c_out_q1}, 2'b00);
        check("reset_out1", {sum1, c_out1}, 2'b00);
        $display("reset: sum_q0=%b c_out_q0=%b sum1=%b c_out1=%b", sum_q0, c_out_q0, sum1, c_out1);

        // Combinational path ignores rst, and no clock edge is needed.
        apply(6);
        #1;
        check("comb_under_rst", {sum0, c_out0}, 2'b01);
        $display("comb under rst: abc=110 sum=%b c_out=%b", sum0, c_out0);

        // Exhaustive truth table on the combinational instance, 20 ns each.
        rst = 1'b0;
        for (int v = 0; v < 8; v++) begin
            apply(v);
            #1;
            check($sformatf("tt_comb_%0d", v), {sum0, c_out0}, exp_tab[v]);
            $display("tt comb: abc=%03b sum=%b c_out=%b", 3'(v), sum0, c_out0);
            #19;
        end

        // Registered latency: the value stays until the next rising edge.
        @(negedge clk);
        apply(0);
        @(posedge clk);
        #1;
        check("lat_prior", {sum_q0, c_out_q0}, 2'b00);
        apply(7);
        #1;
        check("lat_hold_early", {sum_q0, c_out_q0}, 2'b00);
        @(negedge clk);
        check("lat_hold_mid", {sum_q1, c_out_q1}, 2'b00);
        check("lat_comb_now", {sum0, c_out0}, 2'b11);
        @(posedge clk);
        #1;
        check("lat_load_q0", {sum_q0, c_out_q0}, 2'b11);
        check("lat_load_out1", {sum1, c_out1}, 2'b11);
        $display("latency: abc=111 sum_q=%b c_out_q=%b", sum_q0, c_out_q0);

        // Reset priority over the data at the same edge.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_prio_q0", {sum_q0, c_out_q0}, 2'b00);
        check("rst_prio_out1", {sum1, c_out1}, 2'b00);
        check("rst_comb_unaffected", {sum0, c_out0}, 2'b11);
        $display("reset prio: abc=111 rst=1 sum_q=%b c_out_q=%b", sum_q0, c_out_q0);

        // Release after reset: the first edge loads valid data.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("release_q0", {sum_q0, c_out_q0}, 2'b11);
        $display("release: sum_q=%b c_out_q=%b", sum_q0, c_out_q0);

        // Stream all vectors with reset asserted on cycle 4.
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            apply(cyc - 1);
            rst = (cyc == 4);
            @(posedge clk);
            #1;
            exp_v = (cyc == 4) ? 2'b00 : exp_tab[cyc - 1];
            check($sformatf("stream_c%0d", cyc), {sum_q0, c_out_q0}, exp_v);
            $display("stream: cycle=%0d abc=%03b rst=%b sum_q=%b c_out_q=%b",
                     cyc, 3'(cyc - 1), rst, sum_q0, c_out_q0);
        end
        @(negedge clk);
        rst = 1'b0;

        // REG_OUT=1 regression: outputs track the register and lag by one cycle.
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            apply(v);
            #1;
            check($sformatf("reg1_track_pre_%0d", v), {sum1, c_out1}, {sum_q1, c_out_q1});
            @(posedge clk);
            #1;
            check($sformatf("reg1_tt_%0d", v), {sum1, c_out1}, exp_tab[v]);
            check($sformatf("reg1_track_post_%0d", v), {sum1, c_out1}, {sum_q1, c_out_q1});
            $display("reg1: abc=%03b sum=%b c_out=%b", 3'(v), sum1, c_out1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fa_v1.md
FA_V1 -- requirements
Module: fa_v1

Interface
REQ-001 The module SHALL have one parameter: REG_OUT, default 0; 0 selects combinational sum/c_out, 1 selects registered sum/c_out.
REQ-002 The module SHALL declare ports in positional order sum, c_out, a, b, c_in, clk, rst, so that the five data ports keep their established positions.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sum  output  1  sum bit of a + b + c_in.
REQ-006 c_out  output  1  carry-out bit of a + b + c_in.
REQ-007 a  input  1  addend bit.
REQ-008 b  input  1  addend bit.
REQ-009 c_in  input  1  carry-in bit.
REQ-010 sum_q  output  1  registered copy of the sum bit, present for both REG_OUT values.
REQ-011 c_out_q  output  1  registered copy of the carry bit, present for both REG_OUT values.

Function
REQ-012 The block SHALL compute the 2-bit result {carry, s} = a + b + c_in, unsigned.
REQ-013 s SHALL equal a XOR b XOR c_in.
REQ-014 carry SHALL equal (a AND b) OR (a AND c_in) OR (b AND c_in).
REQ-015 With REG_OUT=0, sum and c_out SHALL be pure combinational functions of a, b and c_in.
REQ-016 With REG_OUT=0, sum and c_out SHALL NOT depend on clk or rst.
REQ-017 With REG_OUT=0, sum and c_out SHALL settle within the same time step as any input change.
REQ-018 With REG_OUT=1, sum and c_out SHALL equal sum_q and c_out_q respectively.
REQ-019 On each rising clk edge with rst=0, sum_q and c_out_q SHALL load s and carry from the current a, b, c_in, giving 1-cycle latency.
REQ-020 sum_q and c_out_q SHALL hold their values between rising edges.
REQ-021 Inputs changing between clock edges SHALL affect sum_q and c_out_q only at the next rising edge.
REQ-022 All eight input combinations SHALL be legal, with no illegal or don't-care input states.
REQ-023 The block SHALL contain no other state.

Reset
REQ-024 When rst=1 at a rising clk edge, sum_q and c_out_q SHALL become 0.
REQ-025 rst SHALL take priority over the input data at that edge.
REQ-026 rst asserted mid-operation SHALL clear sum_q and c_out_q at the next rising edge, regardless of a, b and c_in.
REQ-027 rst SHALL have no asynchronous effect.
REQ-028 Until the first rising clk edge, sum_q and c_out_q SHALL be treated as undefined, and benches SHALL apply reset before checking them.
REQ-029 With REG_OUT=0, the combinational sum and c_out SHALL be unaffected by rst.
REQ-030 After rst deasserts, the first rising edge SHALL load valid data into sum_q and c_out_q.

Verification
REQ-031 Exhaustive truth table, REG_OUT=0, 20 ns per vector. For (a,b,c_in) = 000, 001, 010, 011, 100, 101, 110, 111, the required (sum,c_out) are 00, 10, 10, 01, 10, 01, 01, 11.
REQ-032 Combinational independence of reset, REG_OUT=0: hold rst=1 and apply a=1, b=1, c_in=0 -> sum=0 and c_out=1 with no clock edge required.
REQ-033 Registered latency: apply a=1, b=1, c_in=1 -> sum_q and c_out_q stay at their prior values until the next rising edge, then sum_q=1 and c_out_q=1.
REQ-034 Reset priority: with a=b=c_in=1 and rst=1, one rising edge -> sum_q=0 and c_out_q=0.
REQ-035 Release after reset: deassert rst, then one rising edge -> sum_q=1 and c_out_q=1.
REQ-036 Mid-operation reset: stream all eight vectors on consecutive clock cycles and assert rst on cycle 4 -> outputs are 0 on that cycle, and outputs match the truth table for the applied inputs on cycles 5 and later.
REQ-037 REG_OUT=1 regression: rerun the truth-table vectors clocked -> sum and c_out match sum_q and c_out_q on every cycle and follow the truth table one cycle after each vector.
